// File: rtl/pipeline_pkg.sv
// Shared definitions for the interrupt pipeline: FSM encoding, source count,
// default handler-vector layout.
package pipeline_pkg;

    localparam int unsigned IRQ_NUM = 3;
    localparam int unsigned IDX_W   = $clog2(IRQ_NUM);
    localparam int unsigned ST_W    = 2;

    localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_1000;
    localparam int unsigned VEC_STRIDE_DEF = 4;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_INJECT = 2'd1,
        ST_WAIT   = 2'd2
    } int_state_e;

endpackage

// File: rtl/irq_edge_latch.sv
// Rising-edge detector and sticky pending latch for the interrupt lines.
//   irq     : raw lines
//   clr     : per-bit clear mask (a new edge in the same cycle wins)
//   pending : latched requests
module irq_edge_latch #(
    parameter int unsigned N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] irq,
    input  logic [N-1:0] clr,
    output logic [N-1:0] pending
);

    logic [N-1:0] irq_q;
    logic [N-1:0] set_edge;
    logic [N-1:0] pending_d;

    // irq_q resets to 0, so a line held high through reset yields an edge
    assign set_edge  = irq & ~irq_q;
    assign pending_d = (pending & ~clr) | set_edge;

    sync_reset_reg #(.W(N)) u_irq_q (
        .clk (clk),
        .rst (rst),
        .d   (irq),
        .q   (irq_q)
    );

    sync_reset_reg #(.W(N)) u_pending (
        .clk (clk),
        .rst (rst),
        .d   (pending_d),
        .q   (pending)
    );

endmodule

// File: rtl/sync_reset_reg.sv
// Generic register with synchronous active-high reset.
//   clk, rst : clock and synchronous reset
//   d, q     : next value / current value
module sync_reset_reg #(
    parameter int unsigned    W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) q <= RST_VAL;
        else     q <= d;
    end

endmodule

// File: rtl/pipeline_int_ctrl.sv
// Interrupt sequencer: latches irq edges, arbitrates against the in-service
// set, injects one Int_Enter marker into ID/EX and tracks nesting until uret.
//   irq/ie/stall/branch_*/id_pc          : request, enable and pipeline status
//   int_commit/uret_commit               : WB retirement events
//   int_enter/irs/epc/redirect/vector/
//   flush_ifid                           : marker fields, live only in INJECT
//   pending/in_service/busy              : status
module pipeline_int_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned       WIDTH      = 32,
    parameter logic [WIDTH-1:0]  VEC_BASE   = WIDTH'(VEC_BASE_DEF),
    parameter int unsigned       VEC_STRIDE = VEC_STRIDE_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [IRQ_NUM-1:0] irq,
    input  logic               ie,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [WIDTH-1:0]   branch_target,
    input  logic [WIDTH-1:0]   id_pc,
    input  logic               int_commit,
    input  logic               uret_commit,
    output logic               int_enter,
    output logic [IRQ_NUM-1:0] irs,
    output logic [WIDTH-1:0]   epc,
    output logic               redirect,
    output logic [WIDTH-1:0]   vector,
    output logic               flush_ifid,
    output logic [IRQ_NUM-1:0] pending,
    output logic [IRQ_NUM-1:0] in_service,
    output logic               busy
);

    int_state_e         state_q;
    int_state_e         state_d;
    logic [ST_W-1:0]    state_raw;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   idx_d;
    logic [IRQ_NUM-1:0] clr_mask;
    logic [IRQ_NUM-1:0] svc_set;
    logic [IRQ_NUM-1:0] uret_mask;
    logic [IRQ_NUM-1:0] in_service_d;
    logic               svc_valid;
    logic [IDX_W-1:0]   svc_idx;
    logic               elig_valid;
    logic [IDX_W-1:0]   elig_idx;

    irq_edge_latch #(.N(IRQ_NUM)) u_edge_latch (
        .clk     (clk),
        .rst     (rst),
        .irq     (irq),
        .clr     (clr_mask),
        .pending (pending)
    );

    // State, latched source index and in-service set
    sync_reset_reg #(.W(ST_W), .RST_VAL(ST_IDLE)) u_state (
        .clk (clk),
        .rst (rst),
        .d   (state_d),
        .q   (state_raw)
    );
    assign state_q = int_state_e'(state_raw);

    sync_reset_reg #(.W(IDX_W)) u_idx (
        .clk (clk),
        .rst (rst),
        .d   (idx_d),
        .q   (idx_q)
    );

    sync_reset_reg #(.W(IRQ_NUM)) u_in_service (
        .clk (clk),
        .rst (rst),
        .d   (in_service_d),
        .q   (in_service)
    );

    // Priority encoder: a source is eligible only if it outranks everything in service
    always_comb begin
        svc_valid  = 1'b0;
        svc_idx    = '0;
        elig_valid = 1'b0;
        elig_idx   = '0;
        for (int i = 0; i < IRQ_NUM; i++) begin
            if (in_service[i]) begin
                svc_valid = 1'b1;
                svc_idx   = IDX_W'(i);
            end
        end
        for (int i = 0; i < IRQ_NUM; i++) begin
            if (pending[i] && (!svc_valid || (IDX_W'(i) > svc_idx))) begin
                elig_valid = 1'b1;
                elig_idx   = IDX_W'(i);
            end
        end
    end

    // uret retires the innermost (highest) in-service level; a same-cycle accept still sets
    assign uret_mask    = (uret_commit && svc_valid) ? (IRQ_NUM'(1) << svc_idx) : '0;
    assign in_service_d = (in_service & ~uret_mask) | svc_set;
    assign busy         = (state_q != ST_IDLE);

    // Next-state and marker outputs
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        int_enter  = 1'b0;
        irs        = '0;
        epc        = '0;
        redirect   = 1'b0;
        vector     = '0;
        flush_ifid = 1'b0;
        clr_mask   = '0;
        svc_set    = '0;
        case (state_q)
            ST_IDLE: begin
                // a resolving branch owns the redirect this cycle, so defer the accept
                if (elig_valid && ie && !branch_taken) begin
                    state_d = ST_INJECT;
                    idx_d   = elig_idx;
                end
            end
            ST_INJECT: begin
                int_enter  = 1'b1;
                irs        = IRQ_NUM'(1) << idx_q;
                epc        = branch_taken ? branch_target : id_pc;
                redirect   = 1'b1;
                vector     = VEC_BASE + (WIDTH'(VEC_STRIDE) * WIDTH'(idx_q));
                flush_ifid = 1'b1;
                if (!stall) begin
                    svc_set  = IRQ_NUM'(1) << idx_q;
                    clr_mask = IRQ_NUM'(1) << idx_q;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (int_commit) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_pipeline_int_ctrl.sv
module tb_pipeline_int_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  irq;
    logic        ie;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] id_pc;
    logic        int_commit;
    logic        uret_commit;
    logic        int_enter;
    logic [2:0]  irs;
    logic [31:0] epc;
    logic        redirect;
    logic [31:0] vector;
    logic        flush_ifid;
    logic [2:0]  pending;
    logic [2:0]  in_service;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipeline_int_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .irq           (irq),
        .ie            (ie),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .id_pc         (id_pc),
        .int_commit    (int_commit),
        .uret_commit   (uret_commit),
        .int_enter     (int_enter),
        .irs           (irs),
        .epc           (epc),
        .redirect      (redirect),
        .vector        (vector),
        .flush_ifid    (flush_ifid),
        .pending       (pending),
        .in_service    (in_service),
        .busy          (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".int_enter"}, 32'(int_enter), 32'd0);
        chk({tag, ".redirect"}, 32'(redirect), 32'd0);
        chk({tag, ".flush"}, 32'(flush_ifid), 32'd0);
        chk({tag, ".irs"}, 32'(irs), 32'd0);
        chk({tag, ".epc"}, epc, 32'd0);
        chk({tag, ".vector"}, vector, 32'd0);
    endtask

    task automatic chk_inject(input string tag, input logic [2:0] e_irs,
                              input logic [31:0] e_epc, input logic [31:0] e_vec);
        chk({tag, ".int_enter"}, 32'(int_enter), 32'd1);
        chk({tag, ".redirect"}, 32'(redirect), 32'd1);
        chk({tag, ".flush"}, 32'(flush_ifid), 32'd1);
        chk({tag, ".irs"}, 32'(irs), 32'(e_irs));
        chk({tag, ".epc"}, epc, e_epc);
        chk({tag, ".vector"}, vector, e_vec);
        chk({tag, ".busy"}, 32'(busy), 32'd1);
    endtask

    initial begin
        rst = 1'b1; irq = 3'b000; ie = 1'b1; stall = 1'b0;
        branch_taken = 1'b0; branch_target = 32'h0; id_pc = 32'h40;
        int_commit = 1'b0; uret_commit = 1'b0;

        // reset state
        tick(); tick();
        chk_idle("reset");
        chk("reset.pending", 32'(pending), 32'd0);
        chk("reset.in_service", 32'(in_service), 32'd0);
        chk("reset.busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // single source 0: pending next cycle, INJECT the cycle after
        tick(); irq = 3'b001;
        tick();
        chk("s0.pending", 32'(pending), 32'd1);
        chk_idle("s0.pre");
        irq = 3'b000;
        tick();
        chk_inject("s0.inj", 3'b001, 32'h40, 32'h1000);
        tick();
        chk_idle("s0.wait");
        chk("s0.wait.busy", 32'(busy), 32'd1);
        chk("s0.wait.pending", 32'(pending), 32'd0);
        chk("s0.wait.in_service", 32'(in_service), 32'd1);
        int_commit = 1'b1;
        tick(); int_commit = 1'b0;
        chk("s0.commit.busy", 32'(busy), 32'd0);
        chk("s0.commit.in_service", 32'(in_service), 32'd1);
        uret_commit = 1'b1;
        tick(); uret_commit = 1'b0;
        chk("s0.uret.in_service", 32'(in_service), 32'd0);

        // simultaneous edges on 0 and 1: source 1 wins, source 0 waits for uret
        irq = 3'b011;
        tick(); irq = 3'b000;
        chk("dual.pending", 32'(pending), 32'd3);
        tick();
        chk_inject("dual.inj1", 3'b010, 32'h40, 32'h1004);
        chk("dual.inj1.pending", 32'(pending), 32'd3);
        tick();
        chk("dual.wait.pending", 32'(pending), 32'd1);
        chk("dual.wait.in_service", 32'(in_service), 32'd2);
        int_commit = 1'b1;
        tick(); int_commit = 1'b0;
        tick();
        chk_idle("dual.blocked");
        chk("dual.blocked.busy", 32'(busy), 32'd0);
        uret_commit = 1'b1;
        tick(); uret_commit = 1'b0;
        chk("dual.uret.in_service", 32'(in_service), 32'd0);
        chk_idle("dual.uret");
        tick();
        chk_inject("dual.inj0", 3'b001, 32'h40, 32'h1000);
        tick();
        chk("dual.wait0.in_service", 32'(in_service), 32'd1);
        chk("dual.wait0.pending", 32'(pending), 32'd0);
        int_commit = 1'b1;
        tick(); int_commit = 1'b0;

        // nesting: source 2 preempts in-service source 0
        irq = 3'b100;
        tick(); irq = 3'b000;
        chk("nest.pending", 32'(pending), 32'd4);
        tick();
        chk_inject("nest.inj", 3'b100, 32'h40, 32'h1008);
        tick();
        chk("nest.in_service", 32'(in_service), 32'd5);
        int_commit = 1'b1;
        tick(); int_commit = 1'b0;
        uret_commit = 1'b1;
        tick();
        chk("nest.uret1", 32'(in_service), 32'd1);
        tick(); uret_commit = 1'b0;
        chk("nest.uret2", 32'(in_service), 32'd0);

        // stall held 3 cycles in INJECT: int_enter high for exactly 4 cycles
        irq = 3'b001;
        tick(); irq = 3'b000;
        tick();
        chk("stall.c1", 32'(int_enter), 32'd1);
        stall = 1'b1;
        tick();
        chk("stall.c2", 32'(int_enter), 32'd1);
        chk("stall.c2.pending", 32'(pending), 32'd1);
        tick();
        chk("stall.c3", 32'(int_enter), 32'd1);
        tick();
        chk("stall.c4", 32'(int_enter), 32'd1);
        chk("stall.c4.pending", 32'(pending), 32'd1);
        chk("stall.c4.in_service", 32'(in_service), 32'd0);
        stall = 1'b0;
        tick();
        chk("stall.c5", 32'(int_enter), 32'd0);
        chk("stall.c5.pending", 32'(pending), 32'd0);
        chk("stall.c5.in_service", 32'(in_service), 32'd1);
        int_commit = 1'b1; uret_commit = 1'b1;
        tick(); int_commit = 1'b0; uret_commit = 1'b0;
        chk("stall.both.busy", 32'(busy), 32'd0);
        chk("stall.both.in_service", 32'(in_service), 32'd0);

        // branch during INJECT selects epc
        irq = 3'b010;
        tick(); irq = 3'b000;
        tick();
        chk("br.inj.epc_pc", epc, 32'h40);
        branch_taken = 1'b1; branch_target = 32'h80;
        #1;
        chk_inject("br.inj", 3'b010, 32'h80, 32'h1004);
        tick(); branch_taken = 1'b0;
        chk("br.wait.in_service", 32'(in_service), 32'd2);
        int_commit = 1'b1; uret_commit = 1'b1;
        tick(); int_commit = 1'b0; uret_commit = 1'b0;

        // branch in IDLE defers the accept by one cycle
        irq = 3'b001;
        tick(); irq = 3'b000;
        chk("bri.pending", 32'(pending), 32'd1);
        branch_taken = 1'b1;
        tick();
        chk_idle("bri.defer");
        chk("bri.defer.busy", 32'(busy), 32'd0);
        branch_taken = 1'b0;
        tick();
        chk_inject("bri.inj", 3'b001, 32'h40, 32'h1000);
        tick();
        int_commit = 1'b1;
        tick(); int_commit = 1'b0;

        // ie=0 blocks injection; in_service=001 at this point
        ie = 1'b0;
        irq = 3'b100;
        tick(); irq = 3'b000;
        tick(); tick();
        chk_idle("ie0");
        chk("ie0.pending", 32'(pending), 32'd4);
        chk("ie0.busy", 32'(busy), 32'd0);
        ie = 1'b1;
        tick();
        chk_inject("ie1.inj", 3'b100, 32'h40, 32'h1008);
        ie = 1'b0;
        tick();
        chk("iefall.busy", 32'(busy), 32'd1);
        chk("iefall.in_service", 32'(in_service), 32'd5);
        ie = 1'b1;

        // reset in WAIT abandons everything
        rst = 1'b1; irq = 3'b001;
        tick();
        chk_idle("rstwait");
        chk("rstwait.busy", 32'(busy), 32'd0);
        chk("rstwait.in_service", 32'(in_service), 32'd0);
        chk("rstwait.pending", 32'(pending), 32'd0);
        tick();
        chk("rsthold.pending", 32'(pending), 32'd0);
        rst = 1'b0;
        // line held high through reset registers an edge one cycle later
        tick();
        chk("rsthold.edge", 32'(pending), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
